// File: rtl/regfile_write_decoder_if.sv
// Register-file write port bundle: write request handshake, storage-side
// write enable/data, and the read-path hazard probe.
// master = requester / read path / storage side, slave = the decoder.
interface regfile_write_decoder_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic                   wr_valid;
  logic                   wr_ready;
  logic [ADDR_W-1:0]      wr_addr;
  logic [DATA_W-1:0]      wr_data;
  logic                   wb_stall;
  logic [2**ADDR_W-1:0]   we;
  logic [DATA_W-1:0]      we_data;
  logic                   busy;
  logic [ADDR_W-1:0]      rd_addr;
  logic                   rd_hit;
  logic [DATA_W-1:0]      rd_fwd_data;

  modport master (
    output wr_valid, wr_addr, wr_data, wb_stall, rd_addr,
    input  wr_ready, we, we_data, busy, rd_hit, rd_fwd_data
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, wb_stall, rd_addr,
    output wr_ready, we, we_data, busy, rd_hit, rd_fwd_data
  );
endinterface

// File: rtl/regfile_write_decoder.sv
// Register-file write decoder: buffers write requests in a small in-order
// queue and issues one registered one-hot write enable per cycle.
// Address 0 is hardwired zero: it takes a queue slot and an issue cycle but
// never produces a write enable.
// Optional macro REGFILE_FWD_EN builds the pending-write forwarding probe;
// without it rd_hit/rd_fwd_data are tied to zero.
module regfile_write_decoder #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int QDEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  regfile_write_decoder_if.slave   bus
);

  localparam int NREG  = 2**ADDR_W;
  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W = $clog2(QDEPTH + 1);

  // Queue pointer increment with wrap at QDEPTH (no bubble at wrap).
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // ---- p0: pending-write queue ----
  logic [ADDR_W-1:0] r_q_addr_p0 [QDEPTH];
  logic [DATA_W-1:0] r_q_data_p0 [QDEPTH];
  logic [PTR_W-1:0]  r_head_p0;
  logic [PTR_W-1:0]  r_tail_p0;
  logic [CNT_W-1:0]  r_count_p0;

  logic              w_push;
  logic              w_pop;
  logic [ADDR_W-1:0] w_head_addr;
  logic [DATA_W-1:0] w_head_data;
  logic              w_head_nz;
  logic [NREG-1:0]   w_onehot;

  // ---- p1: issued write enable / data ----
  logic [NREG-1:0]   r_we_p1;
  logic [DATA_W-1:0] r_we_data_p1;

  assign bus.wr_ready = (r_count_p0 < CNT_W'(QDEPTH));
  assign w_push       = bus.wr_valid & bus.wr_ready;
  assign w_pop        = (r_count_p0 != '0) & ~bus.wb_stall;
  assign w_head_addr  = r_q_addr_p0[r_head_p0];
  assign w_head_data  = r_q_data_p0[r_head_p0];
  assign w_head_nz    = (w_head_addr != '0);
  assign w_onehot     = w_head_nz ? (NREG'(1) << w_head_addr) : '0;

  // Queue pointers and occupancy; push and pop may both happen in one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head_p0  <= '0;
      r_tail_p0  <= '0;
      r_count_p0 <= '0;
    end else begin
      if (w_push) r_tail_p0 <= next_ptr(r_tail_p0);
      if (w_pop)  r_head_p0 <= next_ptr(r_head_p0);
      case ({w_push, w_pop})
        2'b10:   r_count_p0 <= r_count_p0 + 1'b1;
        2'b01:   r_count_p0 <= r_count_p0 - 1'b1;
        default: r_count_p0 <= r_count_p0;
      endcase
    end
  end

  // Queue payload storage; entries are only meaningful below the count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_addr_p0[r_tail_p0] <= bus.wr_addr;
      r_q_data_p0[r_tail_p0] <= bus.wr_data;
    end
  end

  // Issue the head as a one-hot enable; address 0 pops silently and keeps data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we_p1      <= '0;
      r_we_data_p1 <= '0;
    end else begin
      r_we_p1 <= w_pop ? w_onehot : '0;
      if (w_pop && w_head_nz) r_we_data_p1 <= w_head_data;
    end
  end

  assign bus.we      = r_we_p1;
  assign bus.we_data = r_we_data_p1;
  assign bus.busy    = (r_count_p0 != '0) | (|r_we_p1);

`ifdef REGFILE_FWD_EN
  logic              w_rd_hit;
  logic [DATA_W-1:0] w_rd_fwd_data;
  logic [PTR_W-1:0]  w_idx;

  // Physical slot of the i-th oldest queued entry.
  function automatic logic [PTR_W-1:0] slot_of(input logic [PTR_W-1:0] head, input int i);
    return PTR_W'((int'(head) + i) % QDEPTH);
  endfunction

  // Youngest pending write wins: scan in-flight, then queue oldest to newest.
  always_comb begin
    w_rd_hit      = 1'b0;
    w_rd_fwd_data = '0;
    w_idx         = '0;
    if (bus.rd_addr != '0) begin
      if (r_we_p1[bus.rd_addr]) begin
        w_rd_hit      = 1'b1;
        w_rd_fwd_data = r_we_data_p1;
      end
      for (int i = 0; i < QDEPTH; i++) begin
        w_idx = slot_of(r_head_p0, i);
        if ((CNT_W'(i) < r_count_p0) && (r_q_addr_p0[w_idx] == bus.rd_addr)) begin
          w_rd_hit      = 1'b1;
          w_rd_fwd_data = r_q_data_p0[w_idx];
        end
      end
    end
  end

  assign bus.rd_hit      = w_rd_hit;
  assign bus.rd_fwd_data = w_rd_fwd_data;
`else
  logic w_unused_rd_addr;
  assign w_unused_rd_addr = |bus.rd_addr;
  assign bus.rd_hit       = 1'b0;
  assign bus.rd_fwd_data  = '0;
`endif

endmodule

// File: tb/tb_regfile_write_decoder.sv
// Bench for regfile_write_decoder: directed stimulus, expected write pulses
// queued in a scoreboard and popped by a monitor whenever we is non-zero.
module tb_regfile_write_decoder;

`ifdef REGFILE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk;
  logic rst;

  regfile_write_decoder_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  regfile_write_decoder #(.ADDR_W(5), .DATA_W(32), .QDEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [31:0] we;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && bus.we != '0) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL we_unexpected: got we=%0h data=%0h expected no pulse at %0t",
                 bus.we, bus.we_data, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("we_onehot", 64'($onehot(bus.we)), 64'd1);
        chk("sb_we", 64'(bus.we), 64'(e.we));
        chk("sb_we_data", 64'(bus.we_data), 64'(e.data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one request and wait (bounded) for the edge that accepts it.
  task automatic send(input logic [4:0] a, input logic [31:0] d, input bit expect_it);
    bit   accepted;
    logic rdy;
    logic [31:0] oh;
    accepted = 1'b0;
    if (expect_it && a != 5'd0) begin
      oh = 32'd1 << a;
      sb.push_back({oh, d});
    end
    bus.wr_valid = 1'b1;
    bus.wr_addr  = a;
    bus.wr_data  = d;
    for (int t = 0; t < 50; t++) begin
      rdy = bus.wr_ready;
      tick();
      if (rdy) begin
        accepted = 1'b1;
        break;
      end
    end
    if (!accepted) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: got no accept expected accept for addr %0d", a);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.wb_stall = 1'b0;
    bus.rd_addr  = '0;
    #1 rst = 1'b1;
    #1;
    chk("rst_we", 64'(bus.we), 64'd0);
    chk("rst_we_data", 64'(bus.we_data), 64'd0);
    chk("rst_ready", 64'(bus.wr_ready), 64'd1);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_rd_hit", 64'(bus.rd_hit), 64'd0);
    chk("rst_fwd", 64'(bus.rd_fwd_data), 64'd0);
    #10 rst = 1'b0;
    tick();

    // Single write, latency and busy
    send(5'd5, 32'hDEADBEEF, 1'b1);
    bus.wr_valid = 1'b0;
    chk("single_we_n", 64'(bus.we), 64'd0);
    chk("single_busy_n", 64'(bus.busy), 64'd1);
    tick();
    chk("single_we_n1", 64'(bus.we), 64'h20);
    chk("single_data_n1", 64'(bus.we_data), 64'hDEADBEEF);
    chk("single_busy_n1", 64'(bus.busy), 64'd1);
    tick();
    chk("single_we_n2", 64'(bus.we), 64'd0);
    chk("single_busy_n2", 64'(bus.busy), 64'd0);
    chk("single_hold", 64'(bus.we_data), 64'hDEADBEEF);

    // Back-to-back 1,2,3
    send(5'd1, 32'h11110001, 1'b1);
    chk("b2b_ready1", 64'(bus.wr_ready), 64'd1);
    send(5'd2, 32'h22220002, 1'b1);
    chk("b2b_ready2", 64'(bus.wr_ready), 64'd1);
    chk("b2b_we1", 64'(bus.we), 64'h2);
    send(5'd3, 32'h33330003, 1'b1);
    bus.wr_valid = 1'b0;
    chk("b2b_we2", 64'(bus.we), 64'h4);
    tick();
    chk("b2b_we3", 64'(bus.we), 64'h8);
    tick();
    chk("b2b_idle", 64'(bus.we), 64'd0);

    // Address 0 consumes a slot but never writes
    send(5'd0, 32'h00001234, 1'b0);
    send(5'd4, 32'h44440004, 1'b1);
    bus.wr_valid = 1'b0;
    chk("a0_we", 64'(bus.we), 64'd0);
    chk("a0_data_hold", 64'(bus.we_data), 64'h33330003);
    tick();
    chk("a0_we4", 64'(bus.we), 64'h10);
    chk("a0_data4", 64'(bus.we_data), 64'h44440004);
    tick();

    // Stall fills the queue, third request held until a slot frees
    bus.wb_stall = 1'b1;
    send(5'd7, 32'h07070007, 1'b1);
    send(5'd9, 32'h09090009, 1'b1);
    chk("full_ready", 64'(bus.wr_ready), 64'd0);
    chk("full_we", 64'(bus.we), 64'd0);
    chk("full_busy", 64'(bus.busy), 64'd1);
    sb.push_back({32'h800, 32'h0B0B000B});
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 5'd11;
    bus.wr_data  = 32'h0B0B000B;
    tick();
    chk("full_hold_ready", 64'(bus.wr_ready), 64'd0);
    bus.wb_stall = 1'b0;
    tick();
    chk("full_pop_we", 64'(bus.we), 64'h80);
    chk("full_pop_ready", 64'(bus.wr_ready), 64'd1);
    tick();
    bus.wr_valid = 1'b0;
    chk("full_we9", 64'(bus.we), 64'h200);
    tick();
    chk("full_we11", 64'(bus.we), 64'h800);
    chk("full_data11", 64'(bus.we_data), 64'h0B0B000B);
    tick();

    // Hazard probe
    bus.wb_stall = 1'b1;
    send(5'd6, 32'h0000000A, 1'b1);
    send(5'd6, 32'h0000000B, 1'b1);
    bus.wr_valid = 1'b0;
    bus.rd_addr  = 5'd6;
    #1;
    chk("fwd_hit_q", 64'(bus.rd_hit), 64'(FWD));
    chk("fwd_data_q", 64'(bus.rd_fwd_data), FWD ? 64'hB : 64'h0);
    bus.rd_addr = 5'd0;
    #1;
    chk("fwd_hit_a0", 64'(bus.rd_hit), 64'd0);
    bus.rd_addr = 5'd5;
    #1;
    chk("fwd_hit_miss", 64'(bus.rd_hit), 64'd0);
    bus.rd_addr  = 5'd6;
    bus.wb_stall = 1'b0;
    tick();
    chk("fwd_we_a", 64'(bus.we), 64'h40);
    chk("fwd_data_mix", 64'(bus.rd_fwd_data), FWD ? 64'hB : 64'h0);
    tick();
    chk("fwd_hit_inflight", 64'(bus.rd_hit), 64'(FWD));
    chk("fwd_data_inflight", 64'(bus.rd_fwd_data), FWD ? 64'hB : 64'h0);
    tick();
    chk("fwd_hit_done", 64'(bus.rd_hit), 64'd0);
    chk("fwd_data_done", 64'(bus.rd_fwd_data), 64'd0);

    // Reset mid-operation with two queued writes
    bus.wb_stall = 1'b1;
    send(5'd2, 32'hBAD00002, 1'b0);
    send(5'd3, 32'hBAD00003, 1'b0);
    bus.wr_valid = 1'b0;
    bus.rd_addr  = 5'd2;
    #1;
    chk("pre_rst_hit", 64'(bus.rd_hit), 64'(FWD));
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_we", 64'(bus.we), 64'd0);
    chk("mid_rst_data", 64'(bus.we_data), 64'd0);
    chk("mid_rst_ready", 64'(bus.wr_ready), 64'd1);
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    chk("mid_rst_hit", 64'(bus.rd_hit), 64'd0);
    chk("mid_rst_fwd", 64'(bus.rd_fwd_data), 64'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    bus.wb_stall = 1'b0;
    repeat (6) tick();
    chk("post_rst_ready", 64'(bus.wr_ready), 64'd1);
    chk("post_rst_busy", 64'(bus.busy), 64'd0);

    repeat (2) tick();
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/regfile_write_decoder.md
Name: regfile_write_decoder

Overview:
- Write-side companion to the register file's 32:1 read-select tree.
- Accepts register-write requests over a valid/ready handshake and buffers them in a small in-order queue.
- Decodes each request's 5-bit address into a registered one-hot write-enable vector plus write data, driving the 32-entry storage array one write per cycle.
- Includes a hazard probe so the read path can detect, and optionally forward, writes that are still pending.

Parameters:
- ADDR_W, 5, register address width; number of registers is 2**ADDR_W.
- DATA_W, 32, register data width.
- QDEPTH, 2, pending-write queue depth in entries (min 1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_valid  in  1  write request valid.
- wr_ready  out  1  queue can accept a request.
- wr_addr  in  ADDR_W  destination register.
- wr_data  in  DATA_W  write data.
- wb_stall  in  1  storage array busy; hold the queue head.
- we  out  2**ADDR_W  registered one-hot write enable to storage.
- we_data  out  DATA_W  registered write data, valid when we != 0.
- busy  out  1  queue non-empty or a write is being issued.
- rd_addr  in  ADDR_W  hazard probe address from the read path.
- rd_hit  out  1  pending write to rd_addr exists.
- rd_fwd_data  out  DATA_W  youngest pending data for rd_addr.

Behaviour:
- Reset (async, immediate): queue emptied (count=0, pointers=0), we=0, we_data=0, wr_ready=1, busy=0, rd_hit=0, rd_fwd_data=0.
- Reset mid-operation discards all queued and in-flight writes; no we pulse is produced after rst rises.
- Accept: on an edge where wr_valid & wr_ready, push {wr_addr, wr_data} at the tail.
- wr_ready = (count < QDEPTH). It depends only on registered count; no same-cycle pass-through when full.
- Issue: on each edge where count_before_edge > 0 and wb_stall=0:
  - pop the head;
  - we <= one-hot(head.addr), we_data <= head.data.
- Otherwise we <= 0 and we_data holds its previous value.
- Latency: request accepted at edge N into an empty queue with no stall gives we asserted for exactly one cycle after edge N+1.
- Order: strictly FIFO. Each accepted request produces exactly one issue cycle, except address 0.
- Simultaneous push and pop in one edge: count is unchanged and both take effect.
- Full + pop on same edge: wr_ready stays 0 that cycle and the push is not accepted; wr_ready returns to 1 the next cycle.
- Address 0 is hardwired zero:
  - accepted and occupies a queue slot;
  - when popped, we <= 0 and we_data is unchanged;
  - it still consumes that issue cycle.
- wb_stall=1: no pop, we=0 next cycle; the queue may fill to QDEPTH and then wr_ready=0.
- Pointer wrap: modulo QDEPTH, with no bubble at wrap.
- busy = (count != 0) | (we != 0).
- we is never multi-hot. One-hot decode uses the full ADDR_W bits.

Optional Feature:
- Macro: REGFILE_FWD_EN.
- Defined:
  - rd_hit (combinational) = 1 when rd_addr != 0 and rd_addr matches any valid queue entry or the currently asserted we bit.
  - rd_fwd_data = data of the youngest match, priority tail-most queue entry > head > in-flight we_data; 0 when no hit.
- Undefined: rd_hit and rd_fwd_data are constant 0 and no compare logic is built.

Test Plan:
- Reset: assert rst mid-cycle with 2 queued writes -> outputs at reset values immediately; after release, no we pulse for the discarded entries; wr_ready=1.
- Single write: addr=5, data=0xDEADBEEF accepted at edge N, stall=0 -> we=0x00000020, we_data=0xDEADBEEF for exactly one cycle after edge N+1; busy falls the following cycle.
- Back-to-back: addresses 1,2,3 on consecutive cycles -> we = 0x2, 0x4, 0x8 on consecutive cycles; wr_ready stays 1 throughout.
- Stall/full: wb_stall=1, push addr 7 and addr 9 -> wr_ready=0 after the second accept and a third request is held; release stall -> we=0x80, then 0x200, then the third write, in order.
- Address 0: push addr 0 data 0x1234 then addr 4 -> no we pulse for the first; we=0x10 one cycle later; we_data never shows 0x1234.
- REGFILE_FWD_EN:
  - queue addr 6 = 0xA then addr 6 = 0xB, stall=1, rd_addr=6 -> rd_hit=1, rd_fwd_data=0xB;
  - rd_addr=0 -> rd_hit=0;
  - macro undefined -> rd_hit=0 in both cases.
